// File: rtl/voice_mixer_engine.sv
// voice_mixer_engine
//   Voice scheduler and stereo mixer for the polyphonic synth.
//   - Steps (o_voice_index, o_stage) through every voice, STAGES clocks per voice,
//     to drive the dds/wavetable/ADSR pipeline.
//   - Returned samples are scaled by per-voice left/right gains (g/2^GAIN_W).
//     They are summed into one stereo frame per voice sweep.
//   - Frames leave over a valid/ready handshake. A frame that cannot be delivered
//     is dropped and flagged on o_overrun.
//   - After reset, a NUM_VOICES-cycle sweep loads every gain entry with unity/2
//     (2^(GAIN_W-1)). o_init_busy is high during this sweep.
// Ports
//   i_clk, i_reset                         clock, synchronous active-high reset
//   i_enable                               scheduler advance enable
//   i_cfg_we/i_cfg_voice/i_cfg_gain_l/r    gain table write port
//   o_init_busy                            gain initialisation sweep running
//   o_voice_index, o_stage                 scheduler position
//   i_sample_valid/i_sample_voice/i_sample returned voice samples
//   o_frame_valid/i_frame_ready            frame handshake
//   o_frame_l/o_frame_r                    mixed frame data
//   o_overrun, i_overrun_clr               sticky dropped-frame flag and clear
//   o_clip                                 frame saturated (pulse)
// Build option
//   MIXER_SATURATE_EN: when defined, frames clamp to the OUT_W signed range and
//   o_clip reports clamping. When undefined, frames wrap and o_clip is 0.

// One mixer channel: gain multiply (P2) and accumulate / frame sum (P3).
module voice_mixer_chan #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 8,
    parameter int OUT_W    = 24,
    parameter int ACC_W    = 33
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic signed [SAMPLE_W-1:0] p1_sample,
    input  logic        [GAIN_W-1:0]   p1_gain,
    input  logic                       p2_vld,
    input  logic                       p2_last,
    output logic        [OUT_W-1:0]    frame,
    output logic                       clip
);
    localparam int PW = SAMPLE_W + GAIN_W + 1;

    logic signed [PW-1:0]    prod_full;
    logic        [GAIN_W-1:0] unused_frac;
    logic signed [ACC_W-1:0] p2_prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;

    // The gain is zero-extended so that the product is signed x unsigned.
    // Dropping the low GAIN_W bits gives an arithmetic shift (floor).
    assign prod_full   = PW'(p1_sample) * PW'($signed({1'b0, p1_gain}));
    assign unused_frac = prod_full[GAIN_W-1:0];

    always_ff @(posedge i_clk)
        p2_prod <= ACC_W'($signed(prod_full[PW-1:GAIN_W]));

    assign sum = acc + p2_prod;

    // The last voice of a sweep closes the frame and restarts the accumulator.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            acc <= '0;
        else if (p2_vld)
            acc <= p2_last ? '0 : sum;
    end

`ifdef MIXER_SATURATE_EN
    logic ovf;
    // The sum is out of range unless every bit above the OUT_W sign bit
    // repeats the sign.
    assign ovf = (sum[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){sum[ACC_W-1]}});
    always_comb begin
        frame = sum[OUT_W-1:0];
        if (ovf)
            frame = sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
    end
    assign clip = ovf;
`else
    logic [ACC_W-OUT_W-1:0] unused_sum_hi;
    assign unused_sum_hi = sum[ACC_W-1:OUT_W];
    assign frame = sum[OUT_W-1:0];
    assign clip  = 1'b0;
`endif
endmodule

module voice_mixer_engine #(
    parameter int NUM_VOICES = 256,
    parameter int VOICE_W    = 8,
    parameter int STAGES     = 3,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8,
    parameter int OUT_W      = 24
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_cfg_we,
    input  logic        [VOICE_W-1:0]  i_cfg_voice,
    input  logic        [GAIN_W-1:0]   i_cfg_gain_l,
    input  logic        [GAIN_W-1:0]   i_cfg_gain_r,
    output logic                       o_init_busy,
    output logic        [VOICE_W-1:0]  o_voice_index,
    output logic        [1:0]          o_stage,
    input  logic                       i_sample_valid,
    input  logic        [VOICE_W-1:0]  i_sample_voice,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    output logic                       o_frame_valid,
    input  logic                       i_frame_ready,
    output logic signed [OUT_W-1:0]    o_frame_l,
    output logic signed [OUT_W-1:0]    o_frame_r,
    output logic                       o_overrun,
    input  logic                       i_overrun_clr,
    output logic                       o_clip
);
    localparam int ACC_W      = OUT_W + VOICE_W + 1;
    localparam int MIX_STAGES = 2;

    typedef struct packed {
        logic [GAIN_W-1:0] l;
        logic [GAIN_W-1:0] r;
    } gain_t;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                      state;
    logic [VOICE_W-1:0]          init_ptr;
    gain_t                       gain_tbl [NUM_VOICES];
    logic [MIX_STAGES:1]         vld_pipe;
    logic signed [SAMPLE_W-1:0]  p1_sample;
    logic [VOICE_W-1:0]          p1_voice;
    logic [VOICE_W-1:0]          p2_voice;
    logic [1:0][GAIN_W-1:0]      p1_gain;     // [0] left, [1] right
    logic [1:0][OUT_W-1:0]       frame_sum;
    logic [1:0]                  chan_clip;
    logic                        frame_new;
    logic                        accept;

    // Init sweep: one gain entry per cycle. Busy is registered, so it rises
    // the cycle after reset and falls the cycle after the last entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_INIT;
            init_ptr    <= '0;
            o_init_busy <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    init_ptr <= init_ptr + VOICE_W'(1);
                    if (init_ptr == VOICE_W'(NUM_VOICES-1)) begin
                        state       <= ST_RUN;
                        o_init_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gain table: the init sweep owns the write port until it finishes.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (state == ST_INIT)
                gain_tbl[init_ptr] <= '{l: GAIN_W'(1) << (GAIN_W-1),
                                        r: GAIN_W'(1) << (GAIN_W-1)};
            else if (i_cfg_we)
                gain_tbl[i_cfg_voice] <= '{l: i_cfg_gain_l, r: i_cfg_gain_r};
        end
    end

    // Scheduler
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_voice_index <= '0;
            o_stage       <= '0;
        end else if (i_enable && !o_init_busy) begin
            if (o_stage == 2'(STAGES-1)) begin
                o_stage       <= '0;
                o_voice_index <= o_voice_index + VOICE_W'(1);
            end else begin
                o_stage <= o_stage + 2'd1;
            end
        end
    end

    // Mix pipeline valids
    always_ff @(posedge i_clk) begin
        if (i_reset)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[MIX_STAGES-1:1], i_sample_valid & ~o_init_busy};
    end

    // P1: the table read happens before a same-edge cfg write, so a
    // same-cycle read returns the old gain.
    always_ff @(posedge i_clk) begin
        p1_sample  <= i_sample;
        p1_voice   <= i_sample_voice;
        p1_gain[0] <= gain_tbl[i_sample_voice].l;
        p1_gain[1] <= gain_tbl[i_sample_voice].r;
        p2_voice   <= p1_voice;
    end

    voice_mixer_chan #(
        .SAMPLE_W (SAMPLE_W),
        .GAIN_W   (GAIN_W),
        .OUT_W    (OUT_W),
        .ACC_W    (ACC_W)
    ) u_chan [1:0] (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .p1_sample (p1_sample),
        .p1_gain   (p1_gain),
        .p2_vld    (vld_pipe[2]),
        .p2_last   (p2_voice == VOICE_W'(NUM_VOICES-1)),
        .frame     (frame_sum),
        .clip      (chan_clip)
    );

    assign frame_new = vld_pipe[2] && (p2_voice == VOICE_W'(NUM_VOICES-1));
    assign accept    = o_frame_valid & i_frame_ready;

    // Output frame register and handshake
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_frame_valid <= 1'b0;
            o_frame_l     <= '0;
            o_frame_r     <= '0;
            o_overrun     <= 1'b0;
            o_clip        <= 1'b0;
        end else begin
            o_clip <= 1'b0;
            if (i_overrun_clr)
                o_overrun <= 1'b0;
            if (frame_new) begin
                if (!o_frame_valid || accept) begin
                    o_frame_valid <= 1'b1;
                    o_frame_l     <= frame_sum[0];
                    o_frame_r     <= frame_sum[1];
                    o_clip        <= |chan_clip;
                end else begin
                    // The frame being held wins. The new frame is lost, and
                    // this set overrides a same-cycle clear.
                    o_overrun <= 1'b1;
                end
            end else if (accept) begin
                o_frame_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_voice_mixer_engine.sv
// Directed bench for voice_mixer_engine (4 voices, 3 stages, 16-bit out).
// The test sequence covers:
//   - the init sweep length and the scheduler sequence;
//   - freezing the scheduler with i_enable;
//   - mix arithmetic and the frame latency;
//   - the handshake and overrun behaviour;
//   - cfg read-before-write;
//   - saturation or wrap of the frame;
//   - reset in the middle of a frame.
module tb_voice_mixer_engine;
    localparam int NV = 4, VW = 2, ST = 3, SW = 16, GW = 8, OW = 16;

    logic                 i_clk, i_reset, i_enable;
    logic                 i_cfg_we;
    logic [VW-1:0]        i_cfg_voice;
    logic [GW-1:0]        i_cfg_gain_l, i_cfg_gain_r;
    logic                 o_init_busy;
    logic [VW-1:0]        o_voice_index;
    logic [1:0]           o_stage;
    logic                 i_sample_valid;
    logic [VW-1:0]        i_sample_voice;
    logic signed [SW-1:0] i_sample;
    logic                 o_frame_valid, i_frame_ready;
    logic signed [OW-1:0] o_frame_l, o_frame_r;
    logic                 o_overrun, i_overrun_clr, o_clip;

    int checks = 0;
    int fails  = 0;
    int k;
    int cnt;

    voice_mixer_engine #(
        .NUM_VOICES(NV), .VOICE_W(VW), .STAGES(ST),
        .SAMPLE_W(SW), .GAIN_W(GW), .OUT_W(OW)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_cfg_we(i_cfg_we), .i_cfg_voice(i_cfg_voice),
        .i_cfg_gain_l(i_cfg_gain_l), .i_cfg_gain_r(i_cfg_gain_r),
        .o_init_busy(o_init_busy), .o_voice_index(o_voice_index), .o_stage(o_stage),
        .i_sample_valid(i_sample_valid), .i_sample_voice(i_sample_voice), .i_sample(i_sample),
        .o_frame_valid(o_frame_valid), .i_frame_ready(i_frame_ready),
        .o_frame_l(o_frame_l), .o_frame_r(o_frame_r),
        .o_overrun(o_overrun), .i_overrun_clr(i_overrun_clr), .o_clip(o_clip)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic send_voice(input int v, input int s);
        i_sample_valid = 1'b1;
        i_sample_voice = VW'(v);
        i_sample       = SW'(s);
        @(negedge i_clk);
        i_sample_valid = 1'b0;
    endtask

    task automatic send4(input int s0, input int s1, input int s2, input int s3);
        send_voice(0, s0);
        send_voice(1, s1);
        send_voice(2, s2);
        send_voice(3, s3);
    endtask

    // Called right after the last voice went in. The frame must appear on the
    // third clock after that voice, not earlier.
    task automatic wait_frame(input string tag);
        @(negedge i_clk);
        chk({tag, "_early"}, o_frame_valid, 0);
        @(negedge i_clk);
        chk({tag, "_valid"}, o_frame_valid, 1);
    endtask

    task automatic accept_frame(input string tag);
        i_frame_ready = 1'b1;
        @(negedge i_clk);
        i_frame_ready = 1'b0;
        chk({tag, "_drop"}, o_frame_valid, 0);
    endtask

    task automatic cfg_write(input int v, input int gl, input int gr);
        i_cfg_we     = 1'b1;
        i_cfg_voice  = VW'(v);
        i_cfg_gain_l = GW'(gl);
        i_cfg_gain_r = GW'(gr);
        @(negedge i_clk);
        i_cfg_we = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_init_busy && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        chk(tag, o_init_busy, 0);
    endtask

    initial begin
        i_reset = 1'b1; i_enable = 1'b1; i_cfg_we = 1'b0; i_cfg_voice = '0;
        i_cfg_gain_l = '0; i_cfg_gain_r = '0; i_sample_valid = 1'b0;
        i_sample_voice = '0; i_sample = '0; i_frame_ready = 1'b0; i_overrun_clr = 1'b0;
        repeat (3) @(negedge i_clk);

        // Reset state
        chk("rst_busy", o_init_busy, 1);
        chk("rst_idx", o_voice_index, 0);
        chk("rst_stage", o_stage, 0);
        chk("rst_fvalid", o_frame_valid, 0);
        chk("rst_frame_l", o_frame_l, 0);
        chk("rst_frame_r", o_frame_r, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_clip", o_clip, 0);

        // Init sweep: busy for exactly NV cycles, scheduler held at 0
        i_reset = 1'b0;
        cnt = 0;
        while (o_init_busy && cnt < 20) begin
            cnt++;
            chk("busy_idx", o_voice_index, 0);
            chk("busy_stage", o_stage, 0);
            @(negedge i_clk);
        end
        chk("busy_len", cnt, 4);

        // Scheduler sequence including wrap 3 -> 0
        k = 0;
        for (int i = 0; i < 13; i++) begin
            chk("seq_idx", o_voice_index, (k / 3) % 4);
            chk("seq_stage", o_stage, k % 3);
            k++;
            @(negedge i_clk);
        end
        // Freeze at k=13 (voice 0, stage 1) for 5 cycles
        chk("frz_idx0", o_voice_index, (k / 3) % 4);
        chk("frz_stage0", o_stage, k % 3);
        i_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("frz_idx", o_voice_index, 0);
            chk("frz_stage", o_stage, 1);
        end
        i_enable = 1'b1;
        @(negedge i_clk);
        chk("resume_idx", o_voice_index, 0);
        chk("resume_stage", o_stage, 2);

        // Default gains 128: 1000*128>>8 = 500, x4 = 2000
        send4(1000, 1000, 1000, 1000);
        wait_frame("f1");
        chk("f1_l", o_frame_l, 2000);
        chk("f1_r", o_frame_r, 2000);
        chk("f1_clip", o_clip, 0);
        @(negedge i_clk);
        chk("f1_hold_valid", o_frame_valid, 1);
        chk("f1_hold_l", o_frame_l, 2000);
        accept_frame("f1");

        // Missing voices 1,2 give 0; voice 0 twice is summed: 500+500+500
        send_voice(0, 1000);
        send_voice(0, 1000);
        send_voice(3, 1000);
        wait_frame("dup");
        chk("dup_l", o_frame_l, 1500);
        accept_frame("dup");

        // Floor on negative: -1*128 = -128, >>>8 = -1
        send_voice(0, -1);
        send_voice(3, 0);
        wait_frame("neg");
        chk("neg_l", o_frame_l, -1);
        chk("neg_r", o_frame_r, -1);
        accept_frame("neg");

        // Overrun: second frame dropped, first kept; clear afterwards
        send4(1000, 1000, 1000, 1000);
        wait_frame("ov1");
        chk("ov_pre", o_overrun, 0);
        send4(100, 100, 100, 100);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("ov_set", o_overrun, 1);
        chk("ov_keep_l", o_frame_l, 2000);
        chk("ov_keep_valid", o_frame_valid, 1);
        i_overrun_clr = 1'b1;
        @(negedge i_clk);
        i_overrun_clr = 1'b0;
        chk("ov_clr", o_overrun, 0);
        accept_frame("ov");

        // Per-voice gain: v1 L=0 R=255, -512*255 = -130560, >>>8 = -510
        cfg_write(1, 0, 255);
        send4(0, -512, 0, 0);
        wait_frame("gain");
        chk("gain_l", o_frame_l, 0);
        chk("gain_r", o_frame_r, -510);
        accept_frame("gain");

        // A write in the same cycle as a read of voice 2 returns the old gain (128)
        i_cfg_we = 1'b1; i_cfg_voice = 2'd2; i_cfg_gain_l = 8'd0; i_cfg_gain_r = 8'd0;
        send_voice(2, 1000);
        i_cfg_we = 1'b0;
        send_voice(3, 0);
        wait_frame("rbw");
        chk("rbw_old_l", o_frame_l, 500);
        accept_frame("rbw");
        send_voice(2, 1000);
        send_voice(3, 0);
        wait_frame("rbw2");
        chk("rbw_new_l", o_frame_l, 0);
        accept_frame("rbw2");

        // Full scale: 32767*255>>8 = 32639, x4 = 130556
        for (int v = 0; v < 4; v++) cfg_write(v, 255, 255);
        send4(32767, 32767, 32767, 32767);
        wait_frame("sat");
`ifdef MIXER_SATURATE_EN
        chk("sat_l", o_frame_l, 32767);
        chk("sat_r", o_frame_r, 32767);
        chk("sat_clip", o_clip, 1);
`else
        chk("wrap_l", o_frame_l, -516);
        chk("wrap_r", o_frame_r, -516);
        chk("wrap_clip", o_clip, 0);
`endif
        @(negedge i_clk);
        chk("clip_pulse_end", o_clip, 0);
        accept_frame("sat");

        // Reset with partial sums in the accumulator
        send_voice(0, 1000);
        send_voice(1, 1000);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        chk("mid_rst_busy", o_init_busy, 1);
        chk("mid_rst_valid", o_frame_valid, 0);
        wait_idle("mid_rst_idle");
        send4(10, 10, 10, 10);
        wait_frame("post");
        chk("post_l", o_frame_l, 20);
        chk("post_r", o_frame_r, 20);
        accept_frame("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
